// File: rtl/adbg_wb_slave_if.sv
// Wishbone classic bus bundle between a debug-bus master and the
// adbg_wb_slave memory target.
interface adbg_wb_slave_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        wb_cab_i;

    modport master (
        output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i,
        output wb_sel_i, wb_we_i, wb_cti_i, wb_bte_i, wb_cab_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i,
        input  wb_sel_i, wb_we_i, wb_cti_i, wb_bte_i, wb_cab_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/adbg_wb_slave.sv
// Wishbone classic single-access memory slave with programmable wait
// states, byte-lane writes and error termination on bad index/sel.
module adbg_wb_slave #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 1
) (
    input logic            wb_clk_i,
    input logic            rst_ni,
    adbg_wb_slave_if.slave bus
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] idx_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic        ack_q, err_q;
    logic [31:0] rdat_q;

    logic        req, capture, fire;
    logic [29:0] cur_idx;
    logic [31:0] cur_dat;
    logic [3:0]  cur_sel;
    logic        cur_we;
    logic        sel_ok, idx_ok, cur_err;
    logic [AW-1:0] widx;
    logic        unused_bits;

    logic [31:0] mem [MEM_WORDS];

    assign req = bus.wb_cyc_i && bus.wb_stb_i;
    assign unused_bits = ^{bus.wb_adr_i[1:0], bus.wb_cti_i,
                           bus.wb_bte_i, bus.wb_cab_i};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        fire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        fire    = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the access completes on the capture edge,
    // so the live bus values stand in for the not-yet-captured ones.
    assign cur_idx = capture ? bus.wb_adr_i[31:2] : idx_q;
    assign cur_dat = capture ? bus.wb_dat_i : dat_q;
    assign cur_sel = capture ? bus.wb_sel_i : sel_q;
    assign cur_we  = capture ? bus.wb_we_i : we_q;
    assign widx    = cur_idx[AW-1:0];

    always_comb begin
        sel_ok = 1'b0;
        case (cur_sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: sel_ok = 1'b1;
            default:                   sel_ok = 1'b0;
        endcase
    end

    assign idx_ok  = cur_idx < 30'(MEM_WORDS);
    assign cur_err = !(sel_ok && idx_ok);

    always_ff @(posedge wb_clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 30'd0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q <= bus.wb_adr_i[31:2];
                dat_q <= bus.wb_dat_i;
                sel_q <= bus.wb_sel_i;
                we_q  <= bus.wb_we_i;
            end
            ack_q  <= fire && !cur_err;
            err_q  <= fire && cur_err;
            rdat_q <= (fire && !cur_err && !cur_we) ? mem[widx] : 32'd0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst_ni && fire && cur_we && !cur_err) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_sel[b]) begin
                    mem[widx][8*b +: 8] <= cur_dat[8*b +: 8];
                end
            end
        end
    end

    assign bus.wb_ack_o = ack_q;
    assign bus.wb_err_o = err_q;
    assign bus.wb_dat_o = rdat_q;
endmodule

// File: tb/tb_adbg_wb_slave.sv
// Directed scoreboard bench for adbg_wb_slave at 1, 3 and 0 wait
// states, one instance per setting sharing clock and reset.
module tb_adbg_wb_slave;
    logic clk;
    logic rst_n;

    logic [31:0] t_adr [3];
    logic [31:0] t_dat [3];
    logic [3:0]  t_sel [3];
    logic        t_we  [3];
    logic        t_cyc [3];
    logic        t_stb [3];

    wire [31:0] o_dat [3];
    wire [2:0]  o_ack;
    wire [2:0]  o_err;

    int ws [3] = '{1, 3, 0};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : (g == 1) ? 3 : 0;
        adbg_wb_slave_if bus ();
        assign bus.wb_adr_i = t_adr[g];
        assign bus.wb_dat_i = t_dat[g];
        assign bus.wb_sel_i = t_sel[g];
        assign bus.wb_we_i  = t_we[g];
        assign bus.wb_cyc_i = t_cyc[g];
        assign bus.wb_stb_i = t_stb[g];
        assign bus.wb_cti_i = 3'b000;
        assign bus.wb_bte_i = 2'b00;
        assign bus.wb_cab_i = 1'b0;
        assign o_dat[g] = bus.wb_dat_o;
        assign o_ack[g] = bus.wb_ack_o;
        assign o_err[g] = bus.wb_err_o;
        adbg_wb_slave #(.MEM_WORDS(256), .WAIT_STATES(WS)) u_dut (
            .wb_clk_i (clk),
            .rst_ni   (rst_n),
            .bus      (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
        int          lat;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [3][256];
    logic [31:0] last_rd;
    int          passed = 0;
    int          total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic xfer(input int id, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int lat,
                        input bit keep, input string tag);
        exp_t e;
        logic [29:0] idx;
        bit bad;
        bit got;
        int n;
        idx = adr[31:2];
        bad = (idx >= 256) || !(sel inside {4'b0001, 4'b0010, 4'b0100,
              4'b1000, 4'b0011, 4'b1100, 4'b1111});
        e.lat = lat;
        e.ack = !bad;
        e.err = bad;
        e.dat = 32'd0;
        if (!bad && !we) e.dat = model[id][idx[7:0]];
        if (!bad && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) model[id][idx[7:0]][8*b +: 8] = dat[8*b +: 8];
        end
        sb.push_back(e);
        t_adr[id] = adr;
        t_dat[id] = dat;
        t_sel[id] = sel;
        t_we[id]  = we;
        t_cyc[id] = 1'b1;
        t_stb[id] = 1'b1;
        if (lat == ws[id] + 1) begin
            #1;
            chk({tag, "_comb"}, 64'({o_ack[id], o_err[id]}), 64'd0);
        end
        got = 1'b0;
        n = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            n = k;
            got = o_ack[id] | o_err[id];
        end
        e = sb.pop_front();
        chk({tag, "_done"}, 64'(got), 64'd1);
        chk({tag, "_lat"}, 64'(n), 64'(e.lat));
        chk({tag, "_term"}, 64'({o_ack[id], o_err[id]}),
            64'({e.ack, e.err}));
        chk({tag, "_dat"}, 64'(o_dat[id]), 64'(e.dat));
        last_rd = o_dat[id];
        if (!keep) begin
            t_cyc[id] = 1'b0;
            t_stb[id] = 1'b0;
            @(negedge clk);
            chk({tag, "_after"}, {30'd0, o_ack[id], o_err[id], o_dat[id]},
                64'd0);
        end
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 3; i++) begin
            t_adr[i] = '0; t_dat[i] = '0; t_sel[i] = '0;
            t_we[i] = 1'b0; t_cyc[i] = 1'b0; t_stb[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset%0d", i),
                {30'd0, o_ack[i], o_err[i], o_dat[i]}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // one wait state: basic write/read, lane merges, errors
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 1'b0, "w10");
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 2, 1'b0, "r10");
        chk("r10_const", 64'(last_rd), 64'h0000_0000_DEAD_BEEF);
        xfer(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 2, 1'b0, "w10_b0");
        xfer(0, 1'b1, 32'h10, 32'h12340000, 4'b1100, 2, 1'b0, "w10_hi");
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 2, 1'b0, "r10_mrg");
        chk("r10_mrg_const", 64'(last_rd), 64'h0000_0000_1234_BEAA);
        xfer(0, 1'b0, 32'h400, 32'h0, 4'hF, 2, 1'b0, "r_oob");
        xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0101, 2, 1'b0, "w_sel5");
        xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 2, 1'b0, "w_sel0");
        xfer(0, 1'b0, 32'h13, 32'h0, 4'b0001, 2, 1'b0, "r13");
        chk("r13_const", 64'(last_rd), 64'h0000_0000_1234_BEAA);
        xfer(0, 1'b1, 32'h3FC, 32'hA5A55A5A, 4'hF, 2, 1'b0, "w_last");
        xfer(0, 1'b0, 32'h3FC, 32'h0, 4'b1000, 2, 1'b0, "r_last");
        xfer(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 2, 1'b0, "w30");

        // reset while a write sits in WAIT
        t_adr[0] = 32'h30; t_dat[0] = 32'h0BADF00D; t_sel[0] = 4'hF;
        t_we[0] = 1'b1; t_cyc[0] = 1'b1; t_stb[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_flight", {30'd0, o_ack[0], o_err[0], o_dat[0]}, 64'd0);
        rst_n = 1'b1;
        t_cyc[0] = 1'b0; t_stb[0] = 1'b0;
        @(negedge clk);
        xfer(0, 1'b0, 32'h30, 32'h0, 4'hF, 2, 1'b0, "r30");
        chk("r30_const", 64'(last_rd), 64'h0000_0000_CAFE_F00D);

        // three wait states: abort after two cycles
        xfer(1, 1'b1, 32'h20, 32'h11111111, 4'hF, 4, 1'b0, "w20");
        t_adr[1] = 32'h20; t_dat[1] = 32'h55; t_sel[1] = 4'hF;
        t_we[1] = 1'b1; t_cyc[1] = 1'b1; t_stb[1] = 1'b1;
        repeat (2) @(negedge clk);
        t_stb[1] = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_ack[1] || o_err[1]) seen++;
        end
        t_cyc[1] = 1'b0;
        chk("abort_quiet", 64'(seen), 64'd0);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 4, 1'b0, "r20");
        chk("r20_const", 64'(last_rd), 64'h0000_0000_1111_1111);

        // zero wait states: back-to-back write then read
        xfer(2, 1'b1, 32'h0, 32'h76543210, 4'hF, 1, 1'b1, "b2b_w");
        xfer(2, 1'b0, 32'h0, 32'h0, 4'hF, 2, 1'b0, "b2b_r");
        chk("b2b_const", 64'(last_rd), 64'h0000_0000_7654_3210);
        xfer(2, 1'b0, 32'h404, 32'h0, 4'hF, 1, 1'b0, "ws0_oob");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/adbg_wb_slave.md
ADBG_WB_SLAVE -- requirements
Module: adbg_wb_slave

Interface
REQ-001 SHALL provide parameter MEM_WORDS, default 256, giving the number of 32-bit storage words, legal range 1..1024.
REQ-002 SHALL provide parameter WAIT_STATES, default 1, giving the extra response cycles, legal range 0..15.
REQ-003 SHALL have port wb_clk_i: input, 1 bit, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni: input, 1 bit, reset; synchronous and active-low.
REQ-005 SHALL have port wb_adr_i: input, 32 bits, byte address.
REQ-006 SHALL have port wb_dat_i: input, 32 bits, write data.
REQ-007 SHALL have port wb_dat_o: output, 32 bits, read data.
REQ-008 SHALL have ports wb_cyc_i and wb_stb_i: input, 1 bit each, cycle and strobe.
REQ-009 SHALL have port wb_sel_i: input, 4 bits, byte selects; bit 3 selects bits [31:24].
REQ-010 SHALL have port wb_we_i: input, 1 bit, 1 = write.
REQ-011 SHALL have port wb_ack_o: output, 1 bit, normal termination.
REQ-012 SHALL have port wb_err_o: output, 1 bit, error termination.
REQ-013 SHALL have ports wb_cti_i (3 bits), wb_bte_i (2 bits) and wb_cab_i (1 bit): inputs, accepted and ignored; every access is classic single.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 A request SHALL be wb_cyc_i && wb_stb_i sampled in IDLE.
REQ-016 On a request the block SHALL capture adr, we, sel and dat in the same edge.
REQ-017 On a request the FSM SHALL go to RESP if WAIT_STATES == 0, else to WAIT with a 4-bit counter loaded with WAIT_STATES-1.
REQ-018 In WAIT the counter SHALL decrement each cycle; at 0 with the request still present, the FSM SHALL go to RESP.
REQ-019 Latency: for a request first high in cycle N, termination SHALL be high in cycle N+1+WAIT_STATES and never combinationally in cycle N.
REQ-020 RESP SHALL last exactly one cycle, with exactly one of wb_ack_o or wb_err_o high, then return to IDLE.
REQ-021 wb_ack_o and wb_err_o SHALL never be high simultaneously, and both SHALL be low outside RESP.
REQ-022 Abort: if wb_cyc_i or wb_stb_i is low in any WAIT cycle, the FSM SHALL go to IDLE with no termination and no memory write.
REQ-023 Word index SHALL be captured adr[31:2]; adr[1:0] SHALL be ignored, since the lane is given by sel.
REQ-024 Error conditions:
- index >= MEM_WORDS;
- sel not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111 (0000 included).
REQ-025 On an error condition the block SHALL assert wb_err_o, write nothing and drive wb_dat_o = 0.
REQ-026 A legal write SHALL update only the selected byte lanes of the indexed word, at the edge that raises wb_ack_o.
REQ-027 For a legal read, wb_dat_o SHALL carry the full indexed word (all 32 bits regardless of sel) during the ack cycle, and SHALL be 0 in every other cycle.
REQ-028 Read-after-write SHALL be coherent: a read issued in the IDLE cycle after a write ack SHALL return the new data.
REQ-029 Back-to-back: a request present in the IDLE cycle after RESP SHALL start a new transaction; masters deassert stb in the cycle after termination.
REQ-030 A request already in progress SHALL not be re-sampled; new request inputs SHALL be ignored in WAIT and RESP.

Reset
REQ-031 With rst_ni low at a rising edge, the block SHALL enter state IDLE with counter 0, wb_ack_o 0, wb_err_o 0, wb_dat_o 0 and the captured registers 0.
REQ-032 Reset SHALL override any state; an in-flight transaction SHALL be dropped with no write and no termination.
REQ-033 Memory contents SHALL not be reset; reads before the first write return undefined data.

Verification
REQ-034 Scenario, WAIT_STATES=1: write 0xDEADBEEF, sel 1111, adr 0x10, held until ack; then read adr 0x10 -> ack in cycle N+2 both times, read returns 0xDEADBEEF.
REQ-035 Scenario: over 0xDEADBEEF at adr 0x10, write 0x000000AA with sel 0001; then sel 1100 write 0x12340000 -> read returns 0x1234BEAA.
REQ-036 Scenario: read adr 4*MEM_WORDS (0x400) -> wb_err_o one cycle, wb_ack_o 0, wb_dat_o 0. Write with sel 0101 -> err, and a subsequent read of the target word is unchanged.
REQ-037 Scenario, WAIT_STATES=3: write 0x55 to adr 0x20, drop stb after 2 cycles -> no ack/err ever; a later read of 0x20 returns the prior value.
REQ-038 Scenario: rst_ni low for one cycle during WAIT of a write -> outputs 0 next cycle, word unchanged; a following read completes normally.
REQ-039 Scenario, WAIT_STATES=0: back-to-back write/read of adr 0 -> ack one cycle after each request, with a one-cycle IDLE gap between terminations.
